// File: rtl/window_offset_gen_pkg.sv
// Shared encodings for the window offset generator and its SAD consumers.
// Word-to-byte shift lives here so every stage agrees on it.
package window_offset_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } wog_state_e;

  localparam int ADDR_SHIFT_DEF = 2;

endpackage

// File: rtl/window_offset_gen_scan_counter.sv
// One raster axis: position counter, end-of-axis flag and byte offset.
// The offset is accumulated by a fixed stride, so no multiplier is needed.
module scan_counter #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic              inc,
  input  logic [DIM_W-1:0]  max_in,
  input  logic [ADDR_W-1:0] step_in,
  output logic [DIM_W-1:0]  cnt,
  output logic [ADDR_W-1:0] off,
  output logic [ADDR_W-1:0] off_nxt,
  output logic              at_max
);

  logic [DIM_W-1:0]  max_q;
  logic [ADDR_W-1:0] step_q;
  logic [DIM_W-1:0]  cnt_nxt;

  assign at_max = (cnt >= max_q);

  always_comb begin
    cnt_nxt = cnt;
    off_nxt = off;
    if (load || clr) begin
      cnt_nxt = '0;
      off_nxt = '0;
    end else if (inc) begin
      cnt_nxt = cnt + DIM_W'(1);
      off_nxt = off + step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      off    <= '0;
      max_q  <= '0;
      step_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      off <= off_nxt;
      if (load) begin
        max_q  <= max_in;
        step_q <= step_in;
      end
    end
  end

endmodule

// File: rtl/window_offset_gen.sv
// Raster-scans legal window origins and emits their byte offsets.
// Column axis steps first; row axis advances when the column wraps.
module window_offset_gen
  import window_offset_gen_pkg::*;
#(
  parameter int DIM_W      = 16,
  parameter int ADDR_W     = 32,
  parameter int ADDR_SHIFT = ADDR_SHIFT_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [DIM_W-1:0]  frame_rows,
  input  logic [DIM_W-1:0]  frame_cols,
  input  logic [DIM_W-1:0]  win_rows,
  input  logic [DIM_W-1:0]  win_cols,
  output logic [ADDR_W-1:0] add4_out,
  output logic [DIM_W-1:0]  pos_row,
  output logic [DIM_W-1:0]  pos_col,
  output logic              pos_valid,
  input  logic              pos_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] COL_STEP =
    ADDR_W'(1) << ADDR_SHIFT;

  wog_state_e state_q, state_d;

  logic [DIM_W-1:0]  fr_q, fc_q, wr_q, wc_q;
  logic [ADDR_W-1:0] row_stride;
  logic [ADDR_W-1:0] row_off, col_off;
  logic [ADDR_W-1:0] row_off_nxt, col_off_nxt;
  logic              row_at_max, col_at_max;
  logic              bad, fire, load;
  logic              col_inc, row_inc, last;
  logic              valid_d, busy_d, done_d, err_d;

  assign bad = (fr_q == '0) || (fc_q == '0) ||
               (wr_q == '0) || (wc_q == '0) ||
               (wr_q > fr_q) || (wc_q > fc_q);

  assign row_stride = ADDR_W'(fc_q) << ADDR_SHIFT;
  assign fire    = pos_valid && pos_ready;
  assign load    = (state_q == CHECK) && !bad;
  assign col_inc = (state_q == EMIT) && fire && !col_at_max;
  assign row_inc = (state_q == EMIT) && fire &&
                   col_at_max && !row_at_max;
  assign last    = (state_q == EMIT) && fire &&
                   col_at_max && row_at_max;

  scan_counter #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_col (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load    (load),
    .clr     (row_inc),
    .inc     (col_inc),
    .max_in  (fc_q - wc_q),
    .step_in (COL_STEP),
    .cnt     (pos_col),
    .off     (col_off),
    .off_nxt (col_off_nxt),
    .at_max  (col_at_max)
  );

  scan_counter #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_row (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load    (load),
    .clr     (1'b0),
    .inc     (row_inc),
    .max_in  (fr_q - wr_q),
    .step_in (row_stride),
    .cnt     (pos_row),
    .off     (row_off),
    .off_nxt (row_off_nxt),
    .at_max  (row_at_max)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (Start) state_d = CHECK;
      CHECK:  state_d = bad ? IDLE : EMIT;
      EMIT:   if (last) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE:   busy_d = Start;
      CHECK: begin
        busy_d  = !bad;
        err_d   = bad;
        valid_d = !bad;
      end
      EMIT: begin
        busy_d  = 1'b1;
        valid_d = !last;
      end
      FINISH: done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pos_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      add4_out  <= '0;
      fr_q      <= '0;
      fc_q      <= '0;
      wr_q      <= '0;
      wc_q      <= '0;
    end else begin
      pos_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      add4_out  <= row_off_nxt + col_off_nxt;
      if (state_q == IDLE && Start) begin
        fr_q <= frame_rows;
        fc_q <= frame_cols;
        wr_q <= win_rows;
        wc_q <= win_cols;
      end
    end
  end

endmodule
